lcz80_alu16_seq: RTL and testbench

Sequencer that executes 16-bit ADD HL,rr / ADC HL,rr / SBC HL,rr as two passes through the 8-bit lcz80_alu: low byte, then high byte.
- Drives the ALU's control and data inputs, and captures Q and F_Out from each pass.
- Merges the two passes into a 16-bit result and a final flag byte for the register-file writeback.
- Sits between instruction decode (upstream) and the ALU.

---
 rtl/lcz80_pkg.sv | 70 +++++++
 rtl/lcz80_alu16_seq.sv | 178 +++++++++++++++++
 tb/tb_lcz80_alu16_seq.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcz80_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lcz80_pkg
// Purpose  : Shared definitions for the 16-bit arithmetic sequencer that
//            drives the 8-bit lcz80_alu: ALU_Op encodings, the 16-bit
//            operation encoding, sequencer states and Z80 flag bit indices.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package lcz80_pkg;

  // ALU_Op encodings understood by lcz80_alu (arithmetic group)
  localparam logic [3:0] ALU_OP_ADD = 4'b0000;
  localparam logic [3:0] ALU_OP_ADC = 4'b0001;
  localparam logic [3:0] ALU_OP_SUB = 4'b0010;
  localparam logic [3:0] ALU_OP_SBC = 4'b0011;
  localparam logic [3:0] ALU_OP_AND = 4'b0100;
  localparam logic [3:0] ALU_OP_XOR = 4'b0101;
  localparam logic [3:0] ALU_OP_OR  = 4'b0110;
  localparam logic [3:0] ALU_OP_CP  = 4'b0111;

  // 16-bit operation requested by decode; code 2'b11 is reserved
  typedef enum logic [1:0] {
    OP16_ADD = 2'b00,
    OP16_ADC = 2'b01,
    OP16_SBC = 2'b10,
    OP16_RSV = 2'b11
  } op16_e;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LO   = 2'b01,
    ST_HI   = 2'b10
  } state_e;

  // Z80 flag bit positions
  localparam int FLAG_C  = 0;
  localparam int FLAG_N  = 1;
  localparam int FLAG_PV = 2;
  localparam int FLAG_X  = 3;
  localparam int FLAG_H  = 4;
  localparam int FLAG_Y  = 5;
  localparam int FLAG_Z  = 6;
  localparam int FLAG_S  = 7;

  // ALU_Op for the low-byte pass. Plain ADD starts without carry;
  // ADC/SBC fold the incoming carry into the low byte.
  function automatic logic [3:0] alu_op_lo(input op16_e o);
    logic [3:0] r;
    r = ALU_OP_ADD;
    case (o)
      OP16_ADC: r = ALU_OP_ADC;
      OP16_SBC: r = ALU_OP_SBC;
      default:  r = ALU_OP_ADD;
    endcase
    return r;
  endfunction

  // ALU_Op for the high-byte pass: always the carry-using variant so the
  // carry/borrow from the low pass ripples into the high byte.
  function automatic logic [3:0] alu_op_hi(input op16_e o);
    logic [3:0] r;
    r = ALU_OP_ADC;
    if (o == OP16_SBC) r = ALU_OP_SBC;
    return r;
  endfunction

endpackage : lcz80_pkg
`default_nettype wire

// File: rtl/lcz80_alu16_seq.sv
`default_nettype none
// ============================================================================
// Module   : lcz80_alu16_seq
// Purpose  : Runs ADD HL,rr / ADC HL,rr / SBC HL,rr as two passes through
//            the external 8-bit lcz80_alu (low byte, then high byte) and
//            merges the passes into a 16-bit result and final flag byte.
// Ports    : clk, reset_n        clock / async active-low reset
//            start, op, op_a,    request and operands, sampled in IDLE
//            op_b, f_in
//            busy, done          status; done is a one-cycle pulse
//            result, f_out       registered 16-bit result and flags
//            alu_*  (out)        control/data to the ALU
//            alu_q, alu_f (in)   Q and F_Out from the ALU
//            wz (out, optional)  op_a + 1 captured at start (MEMPTR)
// Options  : LCZ80_ALU16_WZ_EN  adds the wz output and its register
// Revision : 1.0  initial release
// ============================================================================
module lcz80_alu16_seq
  import lcz80_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  input  logic [7:0]  f_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic [7:0]  f_out,
  output logic [3:0]  alu_op,
  output logic        alu_arith16,
  output logic        alu_z16,
  output logic [7:0]  alu_bus_a,
  output logic [7:0]  alu_bus_b,
  output logic [7:0]  alu_f_in,
  input  logic [7:0]  alu_q,
  input  logic [7:0]  alu_f
`ifdef LCZ80_ALU16_WZ_EN
  ,
  output logic [15:0] wz
`endif
);

  state_e      state_q, state_d;
  op16_e       op_q,    op_d;
  logic [15:0] a_q,     a_d;
  logic [15:0] b_q,     b_d;
  logic [7:0]  fl_q,    fl_d;
  logic [7:0]  lo_q,    lo_d;
  logic [7:0]  lo_f_q,  lo_f_d;
  logic [15:0] res_q,   res_d;
  logic [7:0]  f_out_q, f_out_d;
  logic        done_q,  done_d;
`ifdef LCZ80_ALU16_WZ_EN
  logic [15:0] wz_q,    wz_d;
`endif

  // Next-state logic
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    fl_d    = fl_q;
    lo_d    = lo_q;
    lo_f_d  = lo_f_q;
    res_d   = res_q;
    f_out_d = f_out_q;
    done_d  = 1'b0;
`ifdef LCZ80_ALU16_WZ_EN
    wz_d    = wz_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // The reserved code behaves exactly like ADD16, so fold it here
          // and the rest of the datapath only sees three operations.
          op_d    = (op == 2'b11) ? OP16_ADD : op16_e'(op);
          a_d     = op_a;
          b_d     = op_b;
          fl_d    = f_in;
`ifdef LCZ80_ALU16_WZ_EN
          wz_d    = op_a + 16'd1;
`endif
          state_d = ST_LO;
        end
      end
      ST_LO: begin
        lo_d    = alu_q;
        lo_f_d  = alu_f;
        state_d = ST_HI;
      end
      ST_HI: begin
        res_d   = {alu_q, lo_q};
        f_out_d = alu_f;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ALU drive: zero while idle so the shared ALU sees a quiet bus
  always_comb begin
    alu_op      = 4'b0000;
    alu_arith16 = 1'b0;
    alu_z16     = 1'b0;
    alu_bus_a   = 8'h00;
    alu_bus_b   = 8'h00;
    alu_f_in    = 8'h00;
    case (state_q)
      ST_LO: begin
        alu_op      = alu_op_lo(op_q);
        // ADD16 leaves S/Z/P untouched, so the ALU must pass them through
        alu_arith16 = (op_q == OP16_ADD);
        alu_z16     = 1'b0;
        alu_bus_a   = a_q[7:0];
        alu_bus_b   = b_q[7:0];
        alu_f_in    = fl_q;
      end
      ST_HI: begin
        alu_op      = alu_op_hi(op_q);
        alu_arith16 = (op_q == OP16_ADD);
        // For ADC/SBC the ALU ANDs its zero detect with the low-pass Z
        // (carried in via lo_f), giving a true 16-bit zero flag.
        alu_z16     = (op_q != OP16_ADD);
        alu_bus_a   = a_q[15:8];
        alu_bus_b   = b_q[15:8];
        alu_f_in    = lo_f_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP16_ADD;
      a_q     <= 16'h0000;
      b_q     <= 16'h0000;
      fl_q    <= 8'h00;
      lo_q    <= 8'h00;
      lo_f_q  <= 8'h00;
      res_q   <= 16'h0000;
      f_out_q <= 8'h00;
      done_q  <= 1'b0;
`ifdef LCZ80_ALU16_WZ_EN
      wz_q    <= 16'h0000;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      fl_q    <= fl_d;
      lo_q    <= lo_d;
      lo_f_q  <= lo_f_d;
      res_q   <= res_d;
      f_out_q <= f_out_d;
      done_q  <= done_d;
`ifdef LCZ80_ALU16_WZ_EN
      wz_q    <= wz_d;
`endif
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = done_q;
  assign result = res_q;
  assign f_out  = f_out_q;
`ifdef LCZ80_ALU16_WZ_EN
  assign wz     = wz_q;
`endif

endmodule : lcz80_alu16_seq
`default_nettype wire

// File: tb/tb_lcz80_alu16_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcz80_alu16_seq
// Purpose  : Self-checking bench for lcz80_alu16_seq. An 8-bit ALU model
//            stands in for lcz80_alu; results are compared against fixed
//            vectors and a 16-bit arithmetic reference model.
// Options  : LCZ80_ALU16_WZ_EN  connects the optional wz output
// Revision : 1.0  initial release
// ============================================================================
module tb_lcz80_alu16_seq;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [15:0] op_a, op_b;
  logic [7:0]  f_in;
  logic        busy, done;
  logic [15:0] result;
  logic [7:0]  f_out;
  logic [3:0]  alu_op;
  logic        alu_arith16, alu_z16;
  logic [7:0]  alu_bus_a, alu_bus_b, alu_f_in;
  logic [7:0]  alu_q, alu_f;
`ifdef LCZ80_ALU16_WZ_EN
  logic [15:0] wz;
`endif

  int total = 0;
  int bad   = 0;

  lcz80_alu16_seq dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .op          (op),
    .op_a        (op_a),
    .op_b        (op_b),
    .f_in        (f_in),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .f_out       (f_out),
    .alu_op      (alu_op),
    .alu_arith16 (alu_arith16),
    .alu_z16     (alu_z16),
    .alu_bus_a   (alu_bus_a),
    .alu_bus_b   (alu_bus_b),
    .alu_f_in    (alu_f_in),
    .alu_q       (alu_q),
    .alu_f       (alu_f)
`ifdef LCZ80_ALU16_WZ_EN
    ,
    .wz          (wz)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit ALU model (arithmetic ops only): {Q, F_Out}
  function automatic logic [15:0] alu8(input logic [3:0] aop, input logic [7:0] a,
                                       input logic [7:0] b, input logic [7:0] fi,
                                       input logic ar16, input logic z16);
    int ai, bi, ci, r, hn;
    logic sub;
    logic [7:0] q, f;
    sub = aop[1];
    ai  = int'(a);
    bi  = int'(b);
    ci  = aop[0] ? int'(fi[0]) : 0;
    f   = 8'h00;
    if (!sub) begin
      r  = ai + bi + ci;
      hn = (ai % 16) + (bi % 16) + ci;
      q  = r[7:0];
      f[0] = (r > 255);
      f[4] = (hn > 15);
      f[2] = (a[7] == b[7]) && (q[7] != a[7]);
    end else begin
      r  = ai - bi - ci;
      hn = (ai % 16) - (bi % 16) - ci;
      q  = r[7:0];
      f[0] = (r < 0);
      f[4] = (hn < 0);
      f[2] = (a[7] != b[7]) && (q[7] != a[7]);
    end
    f[1] = sub;
    f[7] = q[7];
    f[5] = q[5];
    f[3] = q[3];
    f[6] = (q == 8'h00) ? (z16 ? fi[6] : 1'b1) : 1'b0;
    if (ar16) begin
      f[7] = fi[7];
      f[6] = fi[6];
      f[2] = fi[2];
    end
    return {q, f};
  endfunction

  always_comb begin
    {alu_q, alu_f} = alu8(alu_op, alu_bus_a, alu_bus_b, alu_f_in, alu_arith16, alu_z16);
  end

  // 16-bit reference: {result, flags} straight from Z80 16-bit arithmetic rules
  function automatic logic [23:0] ref16(input logic [1:0] o, input logic [15:0] a,
                                        input logic [15:0] b, input logic [7:0] fi);
    int ai, bi, ci, r;
    logic [15:0] q;
    logic [7:0] f;
    ai = int'(a);
    bi = int'(b);
    ci = int'(fi[0]);
    f  = 8'h00;
    if (o == 2'b10) begin
      r = ai - bi - ci;
      q = r[15:0];
      f[0] = (r < 0);
      f[4] = ((ai % 4096) < (bi % 4096) + ci);
      f[2] = (a[15] != b[15]) && (q[15] != a[15]);
      f[1] = 1'b1;
      f[7] = q[15];
      f[6] = (q == 16'h0000);
    end else if (o == 2'b01) begin
      r = ai + bi + ci;
      q = r[15:0];
      f[0] = (r > 65535);
      f[4] = ((ai % 4096) + (bi % 4096) + ci > 4095);
      f[2] = (a[15] == b[15]) && (q[15] != a[15]);
      f[7] = q[15];
      f[6] = (q == 16'h0000);
    end else begin
      r = ai + bi;
      q = r[15:0];
      f[0] = (r > 65535);
      f[4] = ((ai % 4096) + (bi % 4096) > 4095);
      f[7] = fi[7];
      f[6] = fi[6];
      f[2] = fi[2];
    end
    f[5] = q[13];
    f[3] = q[11];
    return {q, f};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_idle_bus(input string nm);
    chk(nm, {20'h0, alu_op, alu_arith16, alu_z16, alu_bus_a[7:2]}, 32'h0);
    chk(nm, {8'h0, alu_bus_a, alu_bus_b, alu_f_in}, 32'h0);
  endtask

  // Issue one operation starting mid-cycle; returns at E2+1 with the result.
  task automatic do_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                       input logic [7:0] fi, output logic [15:0] res, output logic [7:0] fo);
    logic [3:0] exp_lo, exp_hi;
    exp_lo = (o == 2'b10) ? 4'b0011 : ((o == 2'b01) ? 4'b0001 : 4'b0000);
    exp_hi = (o == 2'b10) ? 4'b0011 : 4'b0001;
    start = 1'b1; op = o; op_a = a; op_b = b; f_in = fi;
    @(posedge clk); #1;                       // E0 passed, in LO
    start = 1'b0; op = 2'($urandom); op_a = 16'($urandom);
    op_b = 16'($urandom); f_in = 8'($urandom);
    chk("busy_lo", 32'(busy), 32'd1);
    chk("done_lo", 32'(done), 32'd0);
    chk("aluop_lo", 32'(alu_op), 32'(exp_lo));
    chk("bus_a_lo", 32'(alu_bus_a), 32'(a[7:0]));
    @(posedge clk); #1;                       // E1 passed, in HI
    chk("busy_hi", 32'(busy), 32'd1);
    chk("done_hi", 32'(done), 32'd0);
    chk("aluop_hi", 32'(alu_op), 32'(exp_hi));
    chk("bus_b_hi", 32'(alu_bus_b), 32'(b[15:8]));
    @(posedge clk); #1;                       // E2 passed
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_end", 32'(busy), 32'd0);
    chk_idle_bus("idle_bus");
    res = result;
    fo  = f_out;
  endtask

  typedef struct {
    logic [1:0]  o;
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  fi;
    logic [15:0] er;
    logic [7:0]  ef;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [15:0] r;
    logic [7:0]  fo;
    logic [23:0] e;
    int n;

    vecs[0] = '{2'b00, 16'h0FFF, 16'h0001, 8'hC4, 16'h1000, 8'hD4};
    vecs[1] = '{2'b01, 16'hFFFF, 16'h0000, 8'h01, 16'h0000, 8'h51};
    vecs[2] = '{2'b10, 16'h8000, 16'h0001, 8'h00, 16'h7FFF, 8'h3E};
    vecs[3] = '{2'b10, 16'h0100, 16'h0100, 8'h00, 16'h0000, 8'h42};
    vecs[4] = '{2'b10, 16'h0100, 16'h0000, 8'h00, 16'h0100, 8'h02};
    vecs[5] = '{2'b00, 16'hFFFF, 16'h0001, 8'h00, 16'h0000, 8'h11};
    vecs[6] = '{2'b11, 16'h1234, 16'h1111, 8'hFF, 16'h2345, 8'hE4};
    vecs[7] = '{2'b01, 16'h7FFF, 16'h0000, 8'h01, 16'h8000, 8'h94};

    reset_n = 1'b0; start = 1'b0; op = 2'b00;
    op_a = 16'h0; op_b = 16'h0; f_in = 8'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_fout", 32'(f_out), 32'd0);
    chk_idle_bus("rst_alu_bus");
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Fixed vectors, issued back to back (each start lands on E3)
    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].o, vecs[i].a, vecs[i].b, vecs[i].fi, r, fo);
      chk($sformatf("vec%0d_result", i), 32'(r), 32'(vecs[i].er));
      chk($sformatf("vec%0d_fout", i), 32'(fo), 32'(vecs[i].ef));
    end

    // Randomized operations against the 16-bit reference
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  ro;
      logic [15:0] ra, rb;
      logic [7:0]  rf;
      ro = 2'($urandom_range(0, 3));
      ra = 16'($urandom);
      rb = 16'($urandom);
      rf = 8'($urandom);
      if (i % 8 == 0) rb = ra;        // push toward zero results
      e = ref16(ro, ra, rb, rf);
      do_op(ro, ra, rb, rf, r, fo);
      chk($sformatf("rnd%0d_result", i), 32'(r), 32'(e[23:8]));
      chk($sformatf("rnd%0d_fout", i), 32'(fo), 32'(e[7:0]));
    end

    // start held through LO: second request ignored, single done
    @(posedge clk); #1;
    start = 1'b1; op = 2'b00; op_a = 16'h1234; op_b = 16'h0101; f_in = 8'h00;
    @(posedge clk); #1;
    op = 2'b10; op_a = 16'hFFFF; op_b = 16'h0F0F; f_in = 8'hFF;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    r = 16'h0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done) begin
        n++;
        r = result;
      end
    end
    e = ref16(2'b00, 16'h1234, 16'h0101, 8'h00);
    chk("busy_start_done_count", 32'(n), 32'd1);
    chk("busy_start_result", 32'(r), 32'(e[23:8]));
    chk("busy_start_fout", 32'(f_out), 32'(e[7:0]));

    // reset_n dropped during HI: outputs clear at once, no done
    start = 1'b1; op = 2'b01; op_a = 16'hABCD; op_b = 16'h1111; f_in = 8'h01;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("pre_reset_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_fout", 32'(f_out), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    n = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) n++;
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    if (done) n++;
    chk("midrst_no_done", 32'(n), 32'd0);
    chk("midrst_result_hold", 32'(result), 32'd0);
    e = ref16(2'b10, 16'h8000, 16'h0001, 8'h00);
    do_op(2'b10, 16'h8000, 16'h0001, 8'h00, r, fo);
    chk("post_rst_result", 32'(r), 32'(e[23:8]));
    chk("post_rst_fout", 32'(fo), 32'(e[7:0]));

    // Result holds while idle
    repeat (3) @(posedge clk);
    #1;
    chk("hold_result", 32'(result), 32'(e[23:8]));
    chk("hold_done_low", 32'(done), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_lcz80_alu16_seq
`default_nettype wire
